// File: rtl/adc_frame_aligner_pkg.sv
// Shared types and sizing helpers for the ADC frame aligner.
package adc_align_pkg;

    // Alignment state machine encoding.
    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } align_state_e;

    localparam int         DEFAULT_LANES         = 4;
    localparam int         DEFAULT_WORD_W        = 8;
    localparam logic [7:0] DEFAULT_FRAME_PATTERN = 8'hF0;
    localparam int         DEFAULT_LOCK_COUNT    = 16;
    localparam int         DEFAULT_UNLOCK_COUNT  = 4;

    // Bits needed to hold a rotation amount 0..word_w-1.
    function automatic int shift_width(input int word_w);
        if (word_w > 1) begin
            return $clog2(word_w);
        end else begin
            return 1;
        end
    endfunction

    // Bits needed to hold a count 0..max_val.
    function automatic int count_width(input int max_val);
        if (max_val > 1) begin
            return $clog2(max_val + 1);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/adc_frame_aligner_if.sv
// Lane input / aligned output bundle between the deserialiser side and the aligner.
interface adc_frame_aligner_if #(
    parameter int LANES  = adc_align_pkg::DEFAULT_LANES,
    parameter int WORD_W = adc_align_pkg::DEFAULT_WORD_W
) ();
    import adc_align_pkg::*;

    localparam int SHIFT_W = shift_width(WORD_W);

    logic                      RESYNC;
    logic                      IN_VALID;
    logic [WORD_W-1:0]         FRAME_IN;
    logic [LANES*WORD_W-1:0]   DATA_IN;
    logic [LANES*WORD_W-1:0]   DATA_OUT;
    logic                      OUT_VALID;
    logic                      ALIGNED;
    logic [SHIFT_W-1:0]        SHIFT_OUT;
    logic [15:0]               ALIGN_ERR_CNT;

    // Source side: drives raw lanes, observes aligned results.
    modport master (
        output RESYNC, IN_VALID, FRAME_IN, DATA_IN,
        input  DATA_OUT, OUT_VALID, ALIGNED, SHIFT_OUT, ALIGN_ERR_CNT
    );

    // Aligner side.
    modport slave (
        input  RESYNC, IN_VALID, FRAME_IN, DATA_IN,
        output DATA_OUT, OUT_VALID, ALIGNED, SHIFT_OUT, ALIGN_ERR_CNT
    );

endinterface

// File: rtl/adc_frame_aligner_bit_window_sel.sv
// Barrel window: picks a WORD_W slice out of {prev, cur} starting s bits below the top.
module bit_window_sel #(
    parameter int WORD_W  = 8,
    parameter int SHIFT_W = 3
) (
    input  logic [WORD_W-1:0]  i_prev,
    input  logic [WORD_W-1:0]  i_cur,
    input  logic [SHIFT_W-1:0] i_shift,
    output logic [WORD_W-1:0]  o_word
);

    logic [2*WORD_W-1:0] w_window;
    logic [2*WORD_W-1:0] w_shifted;

    // Shift the window left by s and keep the upper word; s=0 returns prev untouched.
    always_comb begin
        w_window  = {i_prev, i_cur};
        w_shifted = w_window << i_shift;
        o_word    = w_shifted[2*WORD_W-1 -: WORD_W];
    end

endmodule

// File: rtl/adc_frame_aligner.sv
// Word aligner for 1:8 deserialised ADC lanes: hunts the frame-lane rotation that
// yields FRAME_PATTERN, locks it, and applies the same rotation to every data lane.
module adc_frame_aligner
    import adc_align_pkg::*;
#(
    parameter int                LANES         = DEFAULT_LANES,
    parameter int                WORD_W        = DEFAULT_WORD_W,
    parameter logic [WORD_W-1:0] FRAME_PATTERN = WORD_W'(DEFAULT_FRAME_PATTERN),
    parameter int                LOCK_COUNT    = DEFAULT_LOCK_COUNT,
    parameter int                UNLOCK_COUNT  = DEFAULT_UNLOCK_COUNT
) (
    input  logic                  CLK_IN,
    input  logic                  RESET_N,
    adc_frame_aligner_if.slave    bus
);

    localparam int SHIFT_W = shift_width(WORD_W);
    localparam int MATCH_W = count_width(LOCK_COUNT);
    localparam int MISS_W  = count_width(UNLOCK_COUNT);

    // Next rotation during the hunt, wrapping WORD_W-1 back to 0.
    function automatic logic [SHIFT_W-1:0] next_shift(input logic [SHIFT_W-1:0] s);
        if (s == SHIFT_W'(WORD_W - 1)) begin
            return {SHIFT_W{1'b0}};
        end else begin
            return s + SHIFT_W'(1);
        end
    endfunction

    align_state_e              r_state;
    align_state_e              w_state_nxt;
    logic [SHIFT_W-1:0]        r_shift;
    logic [SHIFT_W-1:0]        w_shift_nxt;
    logic [MATCH_W-1:0]        r_match_cnt;
    logic [MATCH_W-1:0]        w_match_nxt;
    logic [MISS_W-1:0]         r_miss_cnt;
    logic [MISS_W-1:0]         w_miss_nxt;
    logic [15:0]               r_err_cnt;
    logic [15:0]               w_err_nxt;

    logic [WORD_W-1:0]         r_prev_frame;
    logic [LANES*WORD_W-1:0]   r_prev_data;
    logic [WORD_W-1:0]         w_aligned_frame;
    logic [LANES*WORD_W-1:0]   w_aligned_data;
    logic                      w_match;

    logic [LANES*WORD_W-1:0]   r_data_out;
    logic                      r_out_valid;
    logic                      r_aligned;

    // Frame lane selector.
    bit_window_sel #(
        .WORD_W  (WORD_W),
        .SHIFT_W (SHIFT_W)
    ) u_frame_sel (
        .i_prev  (r_prev_frame),
        .i_cur   (bus.FRAME_IN),
        .i_shift (r_shift),
        .o_word  (w_aligned_frame)
    );

    // One selector per data lane, all driven by the frame-derived rotation.
    for (genvar g_l = 0; g_l < LANES; g_l++) begin : g_lane
        bit_window_sel #(
            .WORD_W  (WORD_W),
            .SHIFT_W (SHIFT_W)
        ) u_data_sel (
            .i_prev  (r_prev_data[g_l*WORD_W +: WORD_W]),
            .i_cur   (bus.DATA_IN[g_l*WORD_W +: WORD_W]),
            .i_shift (r_shift),
            .o_word  (w_aligned_data[g_l*WORD_W +: WORD_W])
        );
    end

    assign w_match = (w_aligned_frame == FRAME_PATTERN);

    // Next-state, rotation and counter logic; only IN_VALID cycles advance, RESYNC overrides.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_match_nxt = r_match_cnt;
        w_miss_nxt  = r_miss_cnt;
        w_err_nxt   = r_err_cnt;
        if (bus.RESYNC) begin
            w_state_nxt = ST_SEARCH;
            w_shift_nxt = {SHIFT_W{1'b0}};
            w_match_nxt = {MATCH_W{1'b0}};
            w_miss_nxt  = {MISS_W{1'b0}};
        end else if (bus.IN_VALID) begin
            case (r_state)
                ST_SEARCH: begin
                    if (w_match) begin
                        w_miss_nxt = {MISS_W{1'b0}};
                        if (LOCK_COUNT == 1) begin
                            w_state_nxt = ST_LOCKED;
                            w_match_nxt = {MATCH_W{1'b0}};
                        end else begin
                            w_state_nxt = ST_CHECK;
                            w_match_nxt = MATCH_W'(1);
                        end
                    end else begin
                        w_shift_nxt = next_shift(r_shift);
                    end
                end
                ST_CHECK: begin
                    if (w_match) begin
                        if (r_match_cnt == MATCH_W'(LOCK_COUNT - 1)) begin
                            w_state_nxt = ST_LOCKED;
                            w_match_nxt = {MATCH_W{1'b0}};
                            w_miss_nxt  = {MISS_W{1'b0}};
                        end else begin
                            w_match_nxt = r_match_cnt + MATCH_W'(1);
                        end
                    end else begin
                        w_state_nxt = ST_SEARCH;
                        w_shift_nxt = next_shift(r_shift);
                        w_match_nxt = {MATCH_W{1'b0}};
                    end
                end
                ST_LOCKED: begin
                    if (w_match) begin
                        w_miss_nxt = {MISS_W{1'b0}};
                    end else begin
                        if (r_err_cnt != 16'hFFFF) begin
                            w_err_nxt = r_err_cnt + 16'd1;
                        end else begin
                            w_err_nxt = r_err_cnt;
                        end
                        // Losing lock keeps s so the old rotation is re-tested first.
                        if (r_miss_cnt == MISS_W'(UNLOCK_COUNT - 1)) begin
                            w_state_nxt = ST_SEARCH;
                            w_miss_nxt  = {MISS_W{1'b0}};
                            w_match_nxt = {MATCH_W{1'b0}};
                        end else begin
                            w_miss_nxt = r_miss_cnt + MISS_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_SEARCH;
                    w_shift_nxt = {SHIFT_W{1'b0}};
                    w_match_nxt = {MATCH_W{1'b0}};
                    w_miss_nxt  = {MISS_W{1'b0}};
                end
            endcase
        end else begin
            w_state_nxt = r_state;
            w_shift_nxt = r_shift;
        end
    end

    // State, rotation and counter registers.
    always_ff @(posedge CLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= ST_SEARCH;
            r_shift     <= {SHIFT_W{1'b0}};
            r_match_cnt <= {MATCH_W{1'b0}};
            r_miss_cnt  <= {MISS_W{1'b0}};
            r_err_cnt   <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_match_cnt <= w_match_nxt;
            r_miss_cnt  <= w_miss_nxt;
            r_err_cnt   <= w_err_nxt;
        end
    end

    // Previous-word history; RESYNC leaves it untouched so the window stays continuous.
    always_ff @(posedge CLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            r_prev_frame <= {WORD_W{1'b0}};
            r_prev_data  <= {(LANES*WORD_W){1'b0}};
        end else if (bus.IN_VALID && !bus.RESYNC) begin
            r_prev_frame <= bus.FRAME_IN;
            r_prev_data  <= bus.DATA_IN;
        end else begin
            r_prev_frame <= r_prev_frame;
            r_prev_data  <= r_prev_data;
        end
    end

    // Registered outputs: data/valid reflect the state in force during the input cycle.
    always_ff @(posedge CLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            r_data_out  <= {(LANES*WORD_W){1'b0}};
            r_out_valid <= 1'b0;
            r_aligned   <= 1'b0;
        end else begin
            r_aligned <= (w_state_nxt == ST_LOCKED);
            if (bus.RESYNC) begin
                r_out_valid <= 1'b0;
            end else if (bus.IN_VALID) begin
                r_data_out  <= w_aligned_data;
                r_out_valid <= (r_state == ST_LOCKED);
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.DATA_OUT      = r_data_out;
    assign bus.OUT_VALID     = r_out_valid;
    assign bus.ALIGNED       = r_aligned;
    assign bus.SHIFT_OUT     = r_shift;
    assign bus.ALIGN_ERR_CNT = r_err_cnt;

endmodule

// File: tb/tb_adc_frame_aligner.sv
// Self-checking bench for adc_frame_aligner with a rotation-arithmetic reference model.
module tb_adc_frame_aligner;

    localparam int LOCK_N   = 16;
    localparam int UNLOCK_N = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    adc_frame_aligner_if #(.LANES(4), .WORD_W(8)) bus ();

    adc_frame_aligner dut (
        .CLK_IN  (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0=hunting, 1=confirming, 2=locked.
    int          m_mode, m_shift, m_matches, m_misses, m_err;
    logic [7:0]  m_prev_f;
    logic [31:0] m_prev_d;
    logic [31:0] m_dout;
    logic        m_ovalid, m_aligned;

    // Word seen when {p,c} is read starting k bits below its MSB.
    function automatic logic [7:0] pick(input logic [7:0] p, input logic [7:0] c, input int k);
        logic [15:0] w;
        w = {p, c};
        w = w >> (8 - k);
        return w[7:0];
    endfunction

    task automatic model_reset();
        m_mode = 0; m_shift = 0; m_matches = 0; m_misses = 0; m_err = 0;
        m_prev_f = 8'h00; m_prev_d = 32'h0; m_dout = 32'h0;
        m_ovalid = 1'b0; m_aligned = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] f, input logic [31:0] d, input logic rs);
        logic hit;
        if (rs) begin
            m_mode = 0; m_shift = 0; m_matches = 0; m_misses = 0; m_ovalid = 1'b0;
        end else if (v) begin
            hit = (pick(m_prev_f, f, m_shift) == 8'hF0);
            m_ovalid = (m_mode == 2);
            for (int l = 0; l < 4; l++)
                m_dout[l*8 +: 8] = pick(m_prev_d[l*8 +: 8], d[l*8 +: 8], m_shift);
            m_prev_f = f;
            m_prev_d = d;
            if (m_mode == 2) begin
                if (hit) m_misses = 0;
                else begin
                    m_misses++;
                    if (m_err < 65535) m_err++;
                    if (m_misses == UNLOCK_N) begin m_mode = 0; m_misses = 0; m_matches = 0; end
                end
            end else if (hit) begin
                m_matches = (m_mode == 0) ? 1 : m_matches + 1;
                m_mode = (m_matches >= LOCK_N) ? 2 : 1;
                m_misses = 0;
            end else begin
                m_mode = 0; m_matches = 0; m_shift = (m_shift + 1) % 8;
            end
        end else begin
            m_ovalid = 1'b0;
        end
        m_aligned = (m_mode == 2);
    endtask

    // Drive one clock of inputs and advance the model at the edge.
    task automatic step(input logic v, input logic [7:0] f, input logic [31:0] d, input logic rs);
        bus.IN_VALID = v; bus.FRAME_IN = f; bus.DATA_IN = d; bus.RESYNC = rs;
        @(posedge clk);
        if (rst_n) model_edge(v, f, d, rs);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.IN_VALID = 1'b0; bus.FRAME_IN = 8'h00; bus.DATA_IN = 32'h0; bus.RESYNC = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [20:0] got;
        do_reset();
        got = {bus.ALIGNED, bus.SHIFT_OUT, bus.OUT_VALID, bus.ALIGN_ERR_CNT};
        total++;
        if (got !== 21'h0) begin bad++; $display("FAIL reset_status got=%h exp=0", got); end
        total++;
        if (bus.DATA_OUT !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", bus.DATA_OUT); end
        for (int i = 0; i < 3; i++) step(1'b0, 8'hF0, $urandom, 1'b0);
        total++;
        if (bus.SHIFT_OUT !== 3'd0 || bus.OUT_VALID !== 1'b0) begin
            bad++; $display("FAIL reset_idle_hold shift=%0d ov=%b exp 0/0", bus.SHIFT_OUT, bus.OUT_VALID);
        end
    endtask

    // Constant F0: prev=0 forces a miss at s=0, s walks 1..7, wraps to 0, matches from step 9;
    // 16 matches put ALIGNED high after step 24.
    task automatic test_lock_s0();
        logic [20:0] got, exp;
        int first_lock = 0;
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            step(1'b1, 8'hF0, $urandom, 1'b0);
            got = {bus.ALIGNED, bus.SHIFT_OUT, bus.OUT_VALID, bus.ALIGN_ERR_CNT};
            exp = {m_aligned, 3'(m_shift), m_ovalid, 16'(m_err)};
            total++;
            if (got !== exp) begin bad++; $display("FAIL lock_s0_status step=%0d got=%h exp=%h", i, got, exp); end
            if (m_ovalid) begin
                total++;
                if (bus.DATA_OUT !== m_dout) begin bad++; $display("FAIL lock_s0_data step=%0d got=%h exp=%h", i, bus.DATA_OUT, m_dout); end
            end
            if (first_lock == 0 && bus.ALIGNED === 1'b1) first_lock = i;
        end
        total++;
        if (first_lock != 24) begin bad++; $display("FAIL lock_s0_latency got=%0d exp=24", first_lock); end
        total++;
        if (bus.ALIGNED !== 1'b1 || bus.SHIFT_OUT !== 3'd0) begin
            bad++; $display("FAIL lock_s0_final aligned=%b shift=%0d exp 1/0", bus.ALIGNED, bus.SHIFT_OUT);
        end
    endtask

    // Constant 1E: misses at s=0,1,2, first match at s=3 on step 4, lock after step 19.
    task automatic test_lock_s3();
        logic [20:0] got, exp;
        int first_lock = 0;
        do_reset();
        for (int i = 1; i <= 24; i++) begin
            step(1'b1, 8'h1E, {4{8'h1E}}, 1'b0);
            got = {bus.ALIGNED, bus.SHIFT_OUT, bus.OUT_VALID, bus.ALIGN_ERR_CNT};
            exp = {m_aligned, 3'(m_shift), m_ovalid, 16'(m_err)};
            total++;
            if (got !== exp) begin bad++; $display("FAIL lock_s3_status step=%0d got=%h exp=%h", i, got, exp); end
            if (i <= 3) begin
                total++;
                if (bus.SHIFT_OUT !== 3'(i)) begin bad++; $display("FAIL lock_s3_walk step=%0d got=%0d exp=%0d", i, bus.SHIFT_OUT, i); end
            end
            if (first_lock == 0 && bus.ALIGNED === 1'b1) first_lock = i;
        end
        total++;
        if (first_lock != 19) begin bad++; $display("FAIL lock_s3_latency got=%0d exp=19", first_lock); end
        total++;
        if (bus.SHIFT_OUT !== 3'd3 || bus.DATA_OUT !== 32'hF0F0F0F0 || bus.OUT_VALID !== 1'b1) begin
            bad++; $display("FAIL lock_s3_data shift=%0d data=%h ov=%b exp 3/f0f0f0f0/1", bus.SHIFT_OUT, bus.DATA_OUT, bus.OUT_VALID);
        end
    endtask

    // FE as cur breaks the s=3 frame once; FE as prev still yields F0, so each FE is one miss.
    task automatic test_err_inject();
        logic [20:0] got, exp;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, (i < 3) ? 8'hFE : 8'h1E, $urandom, 1'b0);
            got = {bus.ALIGNED, bus.SHIFT_OUT, bus.OUT_VALID, bus.ALIGN_ERR_CNT};
            exp = {m_aligned, 3'(m_shift), m_ovalid, 16'(m_err)};
            total++;
            if (got !== exp) begin bad++; $display("FAIL err3_status step=%0d got=%h exp=%h", i, got, exp); end
            if (m_ovalid) begin
                total++;
                if (bus.DATA_OUT !== m_dout) begin bad++; $display("FAIL err3_data step=%0d got=%h exp=%h", i, bus.DATA_OUT, m_dout); end
            end
        end
        total++;
        if (bus.ALIGNED !== 1'b1 || bus.ALIGN_ERR_CNT !== 16'd3) begin
            bad++; $display("FAIL err3_kept aligned=%b err=%0d exp 1/3", bus.ALIGNED, bus.ALIGN_ERR_CNT);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 8'hFE, $urandom, 1'b0);
        total++;
        if (bus.ALIGNED !== 1'b0 || bus.SHIFT_OUT !== 3'd3 || bus.ALIGN_ERR_CNT !== 16'd7) begin
            bad++; $display("FAIL err4_unlock aligned=%b shift=%0d err=%0d exp 0/3/7", bus.ALIGNED, bus.SHIFT_OUT, bus.ALIGN_ERR_CNT);
        end
        step(1'b1, 8'h1E, $urandom, 1'b0);
        total++;
        if (bus.SHIFT_OUT !== 3'd3 || bus.ALIGNED !== 1'b0) begin
            bad++; $display("FAIL err4_retry shift=%0d aligned=%b exp 3/0", bus.SHIFT_OUT, bus.ALIGNED);
        end
        for (int i = 0; i < 15; i++) step(1'b1, 8'h1E, $urandom, 1'b0);
        total++;
        if (bus.ALIGNED !== 1'b1 || bus.SHIFT_OUT !== 3'd3) begin
            bad++; $display("FAIL err4_relock aligned=%b shift=%0d exp 1/3", bus.ALIGNED, bus.SHIFT_OUT);
        end
    endtask

    // E1 needs s=7; switching to F0 loses lock, the hunt wraps 7->0 and relocks at 0.
    task automatic test_wrap();
        logic [20:0] got, exp;
        logic [2:0]  last_shift;
        bit          saw_wrap = 1'b0;
        step(1'b0, 8'h00, 32'h0, 1'b1);
        for (int i = 0; i < 30; i++) step(1'b1, 8'hE1, $urandom, 1'b0);
        total++;
        if (bus.ALIGNED !== 1'b1 || bus.SHIFT_OUT !== 3'd7) begin
            bad++; $display("FAIL wrap_s7 aligned=%b shift=%0d exp 1/7", bus.ALIGNED, bus.SHIFT_OUT);
        end
        for (int i = 0; i < 40; i++) begin
            last_shift = bus.SHIFT_OUT;
            step(1'b1, 8'hF0, $urandom, 1'b0);
            if (last_shift == 3'd7 && bus.SHIFT_OUT === 3'd0) saw_wrap = 1'b1;
            got = {bus.ALIGNED, bus.SHIFT_OUT, bus.OUT_VALID, bus.ALIGN_ERR_CNT};
            exp = {m_aligned, 3'(m_shift), m_ovalid, 16'(m_err)};
            total++;
            if (got !== exp) begin bad++; $display("FAIL wrap_status step=%0d got=%h exp=%h", i, got, exp); end
        end
        total++;
        if (!saw_wrap || bus.ALIGNED !== 1'b1 || bus.SHIFT_OUT !== 3'd0) begin
            bad++; $display("FAIL wrap_relock wrap=%b aligned=%b shift=%0d exp 1/1/0", saw_wrap, bus.ALIGNED, bus.SHIFT_OUT);
        end
    endtask

    // Random IN_VALID gaps: lock must take exactly LOCK_N valid matches at s=3.
    task automatic test_valid_toggle();
        logic [20:0] got, exp;
        logic        v;
        int          valid_at_s3 = 0;
        bit          locked = 1'b0;
        step(1'b0, 8'h00, 32'h0, 1'b1);
        for (int i = 0; i < 200; i++) begin
            v = 1'($urandom_range(0, 1));
            if (!locked && v && bus.SHIFT_OUT === 3'd3) valid_at_s3++;
            step(v, 8'h1E, $urandom, 1'b0);
            got = {bus.ALIGNED, bus.SHIFT_OUT, bus.OUT_VALID, bus.ALIGN_ERR_CNT};
            exp = {m_aligned, 3'(m_shift), m_ovalid, 16'(m_err)};
            total++;
            if (got !== exp) begin bad++; $display("FAIL toggle_status step=%0d got=%h exp=%h", i, got, exp); end
            if (!v) begin
                total++;
                if (bus.OUT_VALID !== 1'b0) begin bad++; $display("FAIL toggle_ov_idle step=%0d got=%b exp=0", i, bus.OUT_VALID); end
            end else if (m_ovalid) begin
                total++;
                if (bus.DATA_OUT !== m_dout) begin bad++; $display("FAIL toggle_data step=%0d got=%h exp=%h", i, bus.DATA_OUT, m_dout); end
            end
            if (bus.ALIGNED === 1'b1) locked = 1'b1;
        end
        total++;
        if (!locked || valid_at_s3 != LOCK_N) begin
            bad++; $display("FAIL toggle_lock_count locked=%b valid_matches=%0d exp 1/%0d", locked, valid_at_s3, LOCK_N);
        end
    endtask

    task automatic test_resync();
        logic [20:0] got, exp;
        int          err_before;
        for (int i = 0; i < 3; i++) step(1'b1, 8'h1E, $urandom, 1'b0);
        total++;
        if (bus.ALIGNED !== 1'b1) begin bad++; $display("FAIL resync_pre aligned=%b exp=1", bus.ALIGNED); end
        err_before = m_err;
        step(1'b0, 8'h1E, $urandom, 1'b1);
        got = {bus.ALIGNED, bus.SHIFT_OUT, bus.OUT_VALID, bus.ALIGN_ERR_CNT};
        exp = {1'b0, 3'd0, 1'b0, 16'(err_before)};
        total++;
        if (got !== exp) begin bad++; $display("FAIL resync_clear got=%h exp=%h", got, exp); end
    endtask

    task automatic test_reset_mid();
        logic [20:0] got;
        bit          in_check = 1'b0;
        for (int i = 0; i < 30 && !in_check; i++) begin
            step(1'b1, 8'h1E, $urandom, 1'b0);
            if (m_mode == 1 && m_matches >= 3) in_check = 1'b1;
        end
        total++;
        if (!in_check) begin bad++; $display("FAIL reset_mid_reach_check got=0 exp=1"); end
        #2 rst_n = 1'b0;
        #1;
        got = {bus.ALIGNED, bus.SHIFT_OUT, bus.OUT_VALID, bus.ALIGN_ERR_CNT};
        total++;
        if (got !== 21'h0 || bus.DATA_OUT !== 32'h0) begin
            bad++; $display("FAIL reset_mid_outputs status=%h data=%h exp 0/0", got, bus.DATA_OUT);
        end
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, 8'h1E, $urandom, 1'b0);
        total++;
        if (bus.SHIFT_OUT !== 3'(m_shift) || bus.ALIGN_ERR_CNT !== 16'd0) begin
            bad++; $display("FAIL reset_mid_restart shift=%0d err=%0d exp %0d/0", bus.SHIFT_OUT, bus.ALIGN_ERR_CNT, m_shift);
        end
    endtask

    initial begin
        test_reset();
        test_lock_s0();
        test_lock_s3();
        test_err_inject();
        test_wrap();
        test_valid_toggle();
        test_resync();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
